// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: builds a 15-word (60-byte) ARP reply frame from a
// captured request and streams it out under valid/ready flow control. One
// further request can wait in a single-entry pending slot. Requests that
// arrive while that slot is full are dropped and counted.
//
// Handshake: a word transfers on a rising clock edge where validout=1 and
// txready=1. While validout=1 and txready=0, dataout/sof/eof hold stable.
// validout never drops until the word has transferred.
module arp_reply_tx (
  input  logic        clock,
  input  logic        reset,
  input  logic        arpreq,
  input  logic [47:0] desthwaddr,
  input  logic [31:0] destipaddr,
  input  logic [47:0] inthwaddr,
  input  logic [31:0] intipaddr,
  input  logic        txready,
  output logic        validout,
  output logic        sof,
  output logic        eof,
  output logic [31:0] dataout,
  output logic        busy,
  output logic [7:0]  dropcount,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic        pend_q;
  logic        validout_q, sof_q, eof_q;
  logic [31:0] dataout_q;
  logic [7:0]  dropcount_q;

  // Fields of the frame currently being sent
  logic [47:0] cur_dmac_q, cur_smac_q;
  logic [31:0] cur_dip_q, cur_sip_q;
  // Fields of the queued request
  logic [47:0] pend_dmac_q, pend_smac_q;
  logic [31:0] pend_dip_q, pend_sip_q;

  logic        req_ok_d;
  logic [3:0]  idx_d;
  logic [7:0]  drop_d;

  // Frame layout: Ethernet header, ARP reply body, zero padding to 60 bytes
  function automatic logic [31:0] frame_word(input logic [3:0]  idx,
                                             input logic [47:0] dmac,
                                             input logic [31:0] dip,
                                             input logic [47:0] smac,
                                             input logic [31:0] sip);
    logic [31:0] w;
    w = 32'h0;
    case (idx)
      4'd0:    w = dmac[47:16];
      4'd1:    w = {dmac[15:0], smac[47:32]};
      4'd2:    w = smac[31:0];
      4'd3:    w = 32'h0806_0001;
      4'd4:    w = 32'h0800_0604;
      4'd5:    w = {16'h0002, smac[47:32]};
      4'd6:    w = smac[31:0];
      4'd7:    w = sip;
      4'd8:    w = dmac[47:16];
      4'd9:    w = {dmac[15:0], dip[31:16]};
      4'd10:   w = {dip[15:0], 16'h0000};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // A request counts only once we own a leased IP. Drop counter saturates.
  always_comb begin
    req_ok_d = arpreq && (intipaddr != 32'h0);
    idx_d    = idx_q + 4'd1;
    drop_d   = (dropcount_q == 8'hFF) ? 8'hFF : dropcount_q + 8'd1;
  end

  // Frame sequencer: start, word stepping, pending slot and drop counting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      pend_q      <= 1'b0;
      validout_q  <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      dataout_q   <= 32'h0;
      dropcount_q <= 8'h0;
      cur_dmac_q  <= 48'h0;
      cur_smac_q  <= 48'h0;
      cur_dip_q   <= 32'h0;
      cur_sip_q   <= 32'h0;
      pend_dmac_q <= 48'h0;
      pend_smac_q <= 48'h0;
      pend_dip_q  <= 32'h0;
      pend_sip_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            // The idle cycle after eof has elapsed, so launch the queued frame.
            // The slot is still full this cycle, so a new request is dropped.
            cur_dmac_q <= pend_dmac_q;
            cur_smac_q <= pend_smac_q;
            cur_dip_q  <= pend_dip_q;
            cur_sip_q  <= pend_sip_q;
            pend_q     <= 1'b0;
            state_q    <= SEND;
            idx_q      <= 4'd0;
            validout_q <= 1'b1;
            sof_q      <= 1'b1;
            eof_q      <= 1'b0;
            dataout_q  <= frame_word(4'd0, pend_dmac_q, pend_dip_q,
                                     pend_smac_q, pend_sip_q);
            if (req_ok_d) dropcount_q <= drop_d;
          end else if (req_ok_d) begin
            cur_dmac_q <= desthwaddr;
            cur_smac_q <= inthwaddr;
            cur_dip_q  <= destipaddr;
            cur_sip_q  <= intipaddr;
            state_q    <= SEND;
            idx_q      <= 4'd0;
            validout_q <= 1'b1;
            sof_q      <= 1'b1;
            eof_q      <= 1'b0;
            dataout_q  <= frame_word(4'd0, desthwaddr, destipaddr,
                                     inthwaddr, intipaddr);
          end
        end
        SEND: begin
          if (txready) begin
            if (idx_q == 4'd14) begin
              state_q    <= IDLE;
              idx_q      <= 4'd0;
              validout_q <= 1'b0;
              sof_q      <= 1'b0;
              eof_q      <= 1'b0;
              dataout_q  <= 32'h0;
            end else begin
              idx_q     <= idx_d;
              sof_q     <= 1'b0;
              eof_q     <= (idx_d == 4'd14);
              dataout_q <= frame_word(idx_d, cur_dmac_q, cur_dip_q,
                                      cur_smac_q, cur_sip_q);
            end
          end
          if (req_ok_d) begin
            if (!pend_q) begin
              pend_q      <= 1'b1;
              pend_dmac_q <= desthwaddr;
              pend_smac_q <= inthwaddr;
              pend_dip_q  <= destipaddr;
              pend_sip_q  <= intipaddr;
            end else begin
              dropcount_q <= drop_d;
            end
          end
        end
      endcase
    end
  end

  // Outputs come straight from registers
  always_comb begin
    validout  = validout_q;
    sof       = sof_q;
    eof       = eof_q;
    dataout   = dataout_q;
    dropcount = dropcount_q;
    busy      = (state_q == SEND) || pend_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Bench for arp_reply_tx: randomized and directed requests, reference model
// of frames/pending/drops, scoreboard queue checked by a negedge monitor.
module tb_arp_reply_tx;

  logic        clock;
  logic        reset;
  logic        arpreq;
  logic [47:0] desthwaddr;
  logic [31:0] destipaddr;
  logic [47:0] inthwaddr;
  logic [31:0] intipaddr;
  logic        txready;
  logic        validout, sof, eof, busy, dbg_state;
  logic [31:0] dataout;
  logic [7:0]  dropcount;

  int checks = 0;
  int errors = 0;

  // Expected transfers: {sof, eof, data}
  logic [33:0] exp_q[$];

  // Reference model state
  bit          m_active;
  int          m_left;
  bit          m_pend;
  logic [47:0] pd_dmac, pd_smac;
  logic [31:0] pd_dip, pd_sip;
  int          m_drop;

  arp_reply_tx dut (
    .clock      (clock),
    .reset      (reset),
    .arpreq     (arpreq),
    .desthwaddr (desthwaddr),
    .destipaddr (destipaddr),
    .inthwaddr  (inthwaddr),
    .intipaddr  (intipaddr),
    .txready    (txready),
    .validout   (validout),
    .sof        (sof),
    .eof        (eof),
    .dataout    (dataout),
    .busy       (busy),
    .dropcount  (dropcount),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ARP reply frame built directly from the field layout
  function automatic logic [31:0] exp_word(input int i, input logic [47:0] dmac,
                                           input logic [31:0] dip, input logic [47:0] smac,
                                           input logic [31:0] sip);
    logic [31:0] t[15];
    t[0]  = dmac[47:16];
    t[1]  = {dmac[15:0], smac[47:32]};
    t[2]  = smac[31:0];
    t[3]  = 32'h0806_0001;
    t[4]  = 32'h0800_0604;
    t[5]  = {16'h0002, smac[47:32]};
    t[6]  = smac[31:0];
    t[7]  = sip;
    t[8]  = dmac[47:16];
    t[9]  = {dmac[15:0], dip[31:16]};
    t[10] = {dip[15:0], 16'h0000};
    for (int k = 11; k < 15; k++) t[k] = 32'h0;
    return t[i];
  endfunction

  task automatic start_frame(input logic [47:0] dmac, input logic [31:0] dip,
                             input logic [47:0] smac, input logic [31:0] sip);
    m_active = 1'b1;
    m_left   = 15;
    for (int i = 0; i < 15; i++)
      exp_q.push_back({(i == 0), (i == 14), exp_word(i, dmac, dip, smac, sip)});
  endtask

  task automatic count_drop();
    if (m_drop < 255) m_drop++;
  endtask

  // Model of what happens at the next rising edge given this cycle's inputs
  task automatic model_edge(input bit req, input logic [47:0] dmac, input logic [31:0] dip,
                            input logic [47:0] smac, input logic [31:0] sip, input bit rdy);
    bit valid;
    valid = req && (sip != 32'h0);
    if (m_active) begin
      if (rdy) begin
        m_left--;
        if (m_left == 0) m_active = 1'b0;
      end
      if (valid) begin
        if (!m_pend) begin
          m_pend = 1'b1;
          pd_dmac = dmac; pd_dip = dip; pd_smac = smac; pd_sip = sip;
        end else count_drop();
      end
    end else if (m_pend) begin
      start_frame(pd_dmac, pd_dip, pd_smac, pd_sip);
      m_pend = 1'b0;
      if (valid) count_drop();
    end else if (valid) begin
      start_frame(dmac, dip, smac, sip);
    end
  endtask

  // Driver: check status against the model, then present one cycle of inputs
  task automatic step(input bit req, input logic [47:0] dmac, input logic [31:0] dip,
                      input logic [47:0] smac, input logic [31:0] sip, input bit rdy);
    @(posedge clock);
    #2;
    chk("busy", {31'h0, busy}, {31'h0, (m_active || m_pend)});
    chk("dropcount", {24'h0, dropcount}, m_drop);
    chk("validout", {31'h0, validout}, {31'h0, m_active});
    chk("state", {31'h0, dbg_state}, {31'h0, m_active});
    arpreq     = req;
    desthwaddr = dmac;
    destipaddr = dip;
    inthwaddr  = smac;
    intipaddr  = sip;
    txready    = rdy;
    model_edge(req, dmac, dip, smac, sip, rdy);
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom_range(0, 65535)), 32'($urandom())};
  endfunction

  // Idle cycle with random (ignored) field values on the inputs
  task automatic idle(input bit rdy);
    step(1'b0, rnd48(), $urandom(), rnd48(), $urandom(), rdy);
  endtask

  task automatic rnd_req(input bit rdy);
    step(1'b1, rnd48(), $urandom(), rnd48(), 32'($urandom_range(1, 32'hFFFF_FFFF)), rdy);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    arpreq = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_validout", {31'h0, validout}, 32'h0);
    chk("rst_sof", {31'h0, sof}, 32'h0);
    chk("rst_eof", {31'h0, eof}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_dataout", dataout, 32'h0);
    chk("rst_dropcount", {24'h0, dropcount}, 32'h0);
    exp_q.delete();
    m_active = 1'b0; m_left = 0; m_pend = 1'b0; m_drop = 0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_active || m_pend || exp_q.size() != 0) && n < 400) begin
      idle(1'b1);
      n++;
    end
    repeat (2) idle(1'b1);
    chk("drain_left", exp_q.size(), 32'h0);
  endtask

  // Monitor/scoreboard: pops on each transfer, checks hold during stalls
  logic [33:0] held;
  bit          stalled;
  always @(negedge clock) begin
    logic [33:0] e;
    if (reset) begin
      stalled = 1'b0;
    end else if (validout) begin
      if (stalled) begin
        checks++;
        if ({sof, eof, dataout} !== held) begin
          errors++;
          $display("FAIL hold: got %h expected %h at %0t", {sof, eof, dataout}, held, $time);
        end
      end
      if (txready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h expected none at %0t", {sof, eof, dataout}, $time);
        end else begin
          e = exp_q.pop_front();
          if ({sof, eof, dataout} !== e) begin
            errors++;
            $display("FAIL word: got %h expected %h at %0t", {sof, eof, dataout}, e, $time);
          end
        end
        stalled = 1'b0;
      end else begin
        held    = {sof, eof, dataout};
        stalled = 1'b1;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    reset = 1'b1; arpreq = 1'b0; txready = 1'b0;
    desthwaddr = '0; destipaddr = '0; inthwaddr = '0; intipaddr = '0;
    m_active = 1'b0; m_left = 0; m_pend = 1'b0; m_drop = 0; stalled = 1'b0;
    do_reset();

    // Single reply with full throughput
    step(1'b1, 48'h0011_2233_4455, 32'hC0A8_010A, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0105, 1'b1);
    drain();

    // Backpressure on W3 for five cycles
    step(1'b1, 48'h0011_2233_4455, 32'hC0A8_010A, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0105, 1'b1);
    repeat (3) idle(1'b1);
    repeat (5) idle(1'b0);
    drain();

    // Unleased: request with no own IP is ignored
    step(1'b1, rnd48(), $urandom(), rnd48(), 32'h0, 1'b1);
    repeat (3) idle(1'b1);

    // Three requests during one frame: one queued, one dropped
    rnd_req(1'b1);
    repeat (3) idle(1'b1);
    rnd_req(1'b1);
    repeat (3) idle(1'b1);
    rnd_req(1'b1);
    drain();

    // Request on the eof transfer cycle is queued
    rnd_req(1'b1);
    repeat (14) idle(1'b1);
    rnd_req(1'b1);
    drain();

    // Reset at W7, then a fresh frame
    rnd_req(1'b1);
    repeat (7) idle(1'b1);
    do_reset();
    rnd_req(1'b1);
    drain();

    // Saturation: frame stalled, slot full, 300 more requests
    rnd_req(1'b0);
    rnd_req(1'b0);
    repeat (300) rnd_req(1'b0);
    drain();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit rdy;
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 7) == 0) step(1'b1, rnd48(), $urandom(), rnd48(), 32'h0, rdy);
        else rnd_req(rdy);
      end else begin
        idle(rdy);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
